// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle fetch/decode/execute sequencer that owns the PC and IR.
// Defining STACK_GUARD_EN adds the stack overflow/underflow guard and the FAULT state.
module cpu_control_unit #(
    parameter int unsigned PC_W    = 8,
    parameter logic [4:0]  HALT_OP = 5'h1F
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] rom_addr,
    input  logic [12:0]     q_rom_inst,
    output logic [7:0]      ram_addr,
    output logic            ram_we,
    output logic [2:0]      alu_op,
    output logic            acc_we,
    output logic [1:0]      acc_src,
    output logic [7:0]      imm,
    input  logic            carryOut,
    input  logic            empty,
    input  logic            full,
    output logic            stack_push,
    output logic            stack_pop,
    output logic            stack_sel,
    output logic [PC_W-1:0] pc_ret,
    input  logic [7:0]      stack_output,
    output logic            halted,
    output logic            fault
);

    localparam int unsigned IR_W   = 13;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned DATA_W = 8;

    localparam logic [OP_W-1:0] OP_LDI  = 5'h01;
    localparam logic [OP_W-1:0] OP_LD   = 5'h02;
    localparam logic [OP_W-1:0] OP_ST   = 5'h03;
    localparam logic [OP_W-1:0] OP_JMP  = 5'h08;
    localparam logic [OP_W-1:0] OP_JC   = 5'h09;
    localparam logic [OP_W-1:0] OP_PUSH = 5'h0A;
    localparam logic [OP_W-1:0] OP_POP  = 5'h0B;
    localparam logic [OP_W-1:0] OP_CALL = 5'h0C;
    localparam logic [OP_W-1:0] OP_RET  = 5'h0D;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [PC_W-1:0]     r_pc;
    logic [IR_W-1:0]     r_ir;

    logic [OP_W-1:0]     w_opcode;
    logic [DATA_W-1:0]   w_operand;
    logic                w_is_halt;
    logic                w_is_alu;
    logic                w_needs_mem;
    logic                w_guard_trip;
    logic                w_pc_load;
    logic [PC_W-1:0]     w_pc_target;

    assign w_opcode    = r_ir[IR_W-1:DATA_W];
    assign w_operand   = r_ir[DATA_W-1:0];
    assign w_is_halt   = (w_opcode == HALT_OP);
    assign w_is_alu    = (w_opcode[OP_W-1:2] == 3'b001);
    assign w_needs_mem = (w_opcode == OP_LD) || w_is_alu ||
                         (w_opcode == OP_POP) || (w_opcode == OP_RET);

    // Address/immediate views are pure wiring of PC and IR
    assign rom_addr = r_pc;
    assign pc_ret   = r_pc;
    assign ram_addr = w_operand;
    assign imm      = w_operand;

`ifdef STACK_GUARD_EN
    // A stack op that would overflow/underflow is swallowed and parks the sequencer in FAULT
    assign w_guard_trip = (r_state == S_EXEC) && !w_is_halt &&
                          ((((w_opcode == OP_PUSH) || (w_opcode == OP_CALL)) && full) ||
                           (((w_opcode == OP_POP)  || (w_opcode == OP_RET))  && empty));
    assign fault        = (r_state == S_FAULT);
`else
    logic w_unused_flags;
    assign w_unused_flags = empty ^ full;
    assign w_guard_trip   = 1'b0;
    assign fault          = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: w_next_state = S_EXEC;
            S_EXEC: begin
                if (w_is_halt) begin
                    w_next_state = S_HALT;
                end else if (w_guard_trip) begin
                    w_next_state = S_FAULT;
                end else if (w_needs_mem) begin
                    w_next_state = S_MEM;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_MEM:    w_next_state = S_FETCH;
            S_HALT:   w_next_state = S_HALT;
            S_FAULT:  w_next_state = S_FAULT;
            default:  w_next_state = S_FETCH;
        endcase
    end

    // Control strobes decoded from state and IR
    always_comb begin
        ram_we     = 1'b0;
        alu_op     = 3'd0;
        acc_we     = 1'b0;
        acc_src    = 2'd0;
        stack_push = 1'b0;
        stack_pop  = 1'b0;
        stack_sel  = 1'b0;
        halted     = (r_state == S_HALT) || (r_state == S_FAULT);
        if (r_state == S_EXEC && !w_is_halt) begin
            case (w_opcode)
                OP_LDI: begin
                    acc_we  = 1'b1;
                    acc_src = 2'd1;
                end
                OP_ST:   ram_we = 1'b1;
                OP_PUSH: stack_push = !w_guard_trip;
                OP_CALL: begin
                    stack_push = !w_guard_trip;
                    stack_sel  = 1'b1;
                end
                OP_POP, OP_RET: stack_pop = !w_guard_trip;
                default: ;
            endcase
        end else if (r_state == S_MEM) begin
            if (w_opcode == OP_LD) begin
                acc_we  = 1'b1;
                acc_src = 2'd2;
            end else if (w_is_alu) begin
                acc_we  = 1'b1;
                acc_src = 2'd0;
                alu_op  = 3'(w_opcode - 5'd4);
            end else if (w_opcode == OP_POP) begin
                acc_we  = 1'b1;
                acc_src = 2'd3;
            end
        end
    end

    // PC redirection: jumps/calls in EXEC, return address in MEM
    always_comb begin
        w_pc_load   = 1'b0;
        w_pc_target = PC_W'(w_operand);
        if (r_state == S_EXEC && !w_is_halt) begin
            w_pc_load = (w_opcode == OP_JMP) ||
                        ((w_opcode == OP_JC) && carryOut) ||
                        ((w_opcode == OP_CALL) && !w_guard_trip);
        end else if (r_state == S_MEM && w_opcode == OP_RET) begin
            w_pc_load   = 1'b1;
            w_pc_target = PC_W'(stack_output);
        end
    end

    // PC and IR registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= '0;
            r_ir <= '0;
        end else if (r_state == S_DECODE) begin
            r_ir <= q_rom_inst;
            r_pc <= r_pc + PC_W'(1);
        end else if (w_pc_load) begin
            r_pc <= w_pc_target;
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: ROM/RAM/stack/accumulator model around the sequencer,
// strobe events checked against a scoreboard of expected events per program.
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rom_addr;
    logic [12:0] q_rom_inst;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [2:0]  alu_op;
    logic        acc_we;
    logic [1:0]  acc_src;
    logic [7:0]  imm;
    logic        carryOut;
    logic        empty;
    logic        full;
    logic        stack_push;
    logic        stack_pop;
    logic        stack_sel;
    logic [7:0]  pc_ret;
    logic [7:0]  stack_output;
    logic        halted;
    logic        fault;

    int vectors = 0;
    int miscompares = 0;

    logic [12:0] rom [0:255];
    logic [7:0]  ram [0:255];
    logic [7:0]  stk [0:15];
    int          sp;
    logic [7:0]  acc;
    logic        carry;
    logic [7:0]  q_ram;
    logic [8:0]  w_alu;
    logic [7:0]  w_acc_next;
    logic [7:0]  w_push_data;
    logic [31:0] exp_q [$];

    localparam logic [12:0] HLT = {5'h1F, 8'h00};

    cpu_control_unit #(.PC_W(8), .HALT_OP(5'h1F)) dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .q_rom_inst(q_rom_inst),
        .ram_addr(ram_addr), .ram_we(ram_we), .alu_op(alu_op), .acc_we(acc_we),
        .acc_src(acc_src), .imm(imm), .carryOut(carryOut), .empty(empty), .full(full),
        .stack_push(stack_push), .stack_pop(stack_pop), .stack_sel(stack_sel),
        .pc_ret(pc_ret), .stack_output(stack_output), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    // Datapath model: ALU, accumulator source mux, RAM, ROM, stack
    always_comb begin
        case (alu_op)
            3'd0:    w_alu = {1'b0, acc} + {1'b0, q_ram};
            3'd1:    w_alu = {1'b0, acc} - {1'b0, q_ram};
            3'd2:    w_alu = {1'b0, acc & q_ram};
            3'd3:    w_alu = {1'b0, acc | q_ram};
            default: w_alu = 9'd0;
        endcase
        case (acc_src)
            2'd0:    w_acc_next = w_alu[7:0];
            2'd1:    w_acc_next = imm;
            2'd2:    w_acc_next = q_ram;
            default: w_acc_next = stack_output;
        endcase
        w_push_data = stack_sel ? pc_ret : acc;
    end

    assign carryOut = carry;
    assign empty    = (sp == 0);
    assign full     = (sp == 16);

    always @(posedge clk) begin
        q_rom_inst <= rom[rom_addr];
        q_ram      <= ram[ram_addr];
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sp    <= 0;
            acc   <= 8'h00;
            carry <= 1'b0;
        end else begin
            if (acc_we) acc <= w_acc_next;
            if (acc_we && acc_src == 2'd0) carry <= w_alu[8];
            if (ram_we) ram[ram_addr] <= acc;
            if (stack_push && sp < 16) begin
                stk[sp[3:0]] <= w_push_data;
                sp <= sp + 1;
            end else if (stack_pop) begin
                if (sp > 0) begin
                    stack_output <= stk[4'(sp - 1)];
                    sp <= sp - 1;
                end else begin
                    stack_output <= 8'h00;
                end
            end
        end
    end

    function automatic logic [31:0] ev(input logic [3:0] k, input logic [3:0] s,
                                       input logic [3:0] a, input logic [7:0] ad, input logic [7:0] d);
        return {4'h0, k, s, a, ad, d};
    endfunction

    function automatic logic [12:0] ins(input logic [4:0] op, input logic [7:0] arg);
        return {op, arg};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_compare(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            check("sb_unexpected_event", obs, 32'h0);
        end else begin
            check("sb_event", obs, exp_q.pop_front());
        end
    endtask

    // Strobe monitor: each committed strobe becomes one scoreboard event
    always @(negedge clk) begin
        if (!reset) begin
            if (acc_we)     sb_compare(ev(4'd1, 4'(acc_src), 4'(alu_op), 8'h00, w_acc_next));
            if (ram_we)     sb_compare(ev(4'd2, 4'd0, 4'd0, ram_addr, acc));
            if (stack_push) sb_compare(ev(4'd3, 4'(stack_sel), 4'd0, 8'h00, w_push_data));
            if (stack_pop)  sb_compare(ev(4'd4, 4'd0, 4'd0, 8'h00, 8'h00));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = HLT;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        #1;
        check("rst_addrs", {rom_addr, ram_addr, imm, pc_ret}, 32'h0);
        check("rst_ctrl", {20'h0, alu_op, acc_src, acc_we, ram_we, stack_push, stack_pop,
                           stack_sel, halted, fault}, 32'h0);
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halted && n < 400) begin
            tick();
            n++;
        end
        check(tag, 32'(halted), 32'h1);
    endtask

    task automatic end_program(input string tag);
        check(tag, 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    initial begin
        int n;

        // LDI then HLT: exact cycle timing of EXEC and HALT
        clear_rom();
        rom[0] = ins(5'h01, 8'h2A);
        rom[1] = HLT;
        exp_q.push_back(ev(4'd1, 4'd1, 4'd0, 8'h00, 8'h2A));
        reset_dut();
        tick(); tick();
        check("t1_ldi_exec_cycle3", {imm, 6'h0, acc_src, 7'h0, acc_we}, {8'h2A, 6'h0, 2'd1, 7'h0, 1'b1});
        tick(); tick(); tick();
        check("t1_not_halted_cycle5", 32'(halted), 32'h0);
        tick();
        check("t1_halted_cycle6", 32'(halted), 32'h1);
        tick(); tick(); tick();
        check("t1_halt_absorbing", {24'h0, rom_addr}, {31'h0, halted} + 32'h1);
        check("t1_acc", 32'(acc), 32'h2A);
        end_program("t1_sb_drained");

        // LDI/ST/LDI/ADD with carry, JC taken to 0x20
        clear_rom();
        rom[0] = ins(5'h01, 8'hFF);
        rom[1] = ins(5'h03, 8'h10);
        rom[2] = ins(5'h01, 8'h01);
        rom[3] = ins(5'h04, 8'h10);
        rom[4] = ins(5'h09, 8'h20);
        rom[8'h20] = ins(5'h1F, 8'h77);
        exp_q.push_back(ev(4'd1, 4'd1, 4'd0, 8'h00, 8'hFF));
        exp_q.push_back(ev(4'd2, 4'd0, 4'd0, 8'h10, 8'hFF));
        exp_q.push_back(ev(4'd1, 4'd1, 4'd0, 8'h00, 8'h01));
        exp_q.push_back(ev(4'd1, 4'd0, 4'd0, 8'h00, 8'h00));
        reset_dut();
        wait_halt("t2_halt");
        check("t2_ram10", 32'(ram[8'h10]), 32'hFF);
        check("t2_pc_at_halt", 32'(rom_addr), 32'h21);
        check("t2_halt_imm", 32'(imm), 32'h77);
        end_program("t2_sb_drained");

        // ALU variants, LD, and an undefined opcode acting as NOP
        clear_rom();
        rom[0] = ins(5'h01, 8'h0F);
        rom[1] = ins(5'h03, 8'h20);
        rom[2] = ins(5'h01, 8'h3C);
        rom[3] = ins(5'h06, 8'h20);
        rom[4] = ins(5'h07, 8'h20);
        rom[5] = ins(5'h05, 8'h20);
        rom[6] = ins(5'h0E, 8'h00);
        rom[7] = ins(5'h02, 8'h20);
        exp_q.push_back(ev(4'd1, 4'd1, 4'd0, 8'h00, 8'h0F));
        exp_q.push_back(ev(4'd2, 4'd0, 4'd0, 8'h20, 8'h0F));
        exp_q.push_back(ev(4'd1, 4'd1, 4'd0, 8'h00, 8'h3C));
        exp_q.push_back(ev(4'd1, 4'd0, 4'd2, 8'h00, 8'h0C));
        exp_q.push_back(ev(4'd1, 4'd0, 4'd3, 8'h00, 8'h0F));
        exp_q.push_back(ev(4'd1, 4'd0, 4'd1, 8'h00, 8'h00));
        exp_q.push_back(ev(4'd1, 4'd2, 4'd0, 8'h00, 8'h0F));
        reset_dut();
        wait_halt("t3_halt");
        check("t3_pc_at_halt", 32'(rom_addr), 32'h09);
        end_program("t3_sb_drained");

        // CALL 0x40 from 0x05, RET back to 0x06
        clear_rom();
        for (int i = 0; i < 5; i++) rom[i] = ins(5'h00, 8'h00);
        rom[5] = ins(5'h0C, 8'h40);
        rom[8'h40] = ins(5'h0D, 8'h00);
        exp_q.push_back(ev(4'd3, 4'd1, 4'd0, 8'h00, 8'h06));
        exp_q.push_back(ev(4'd4, 4'd0, 4'd0, 8'h00, 8'h00));
        reset_dut();
        n = 0;
        while (!stack_pop && n < 60) begin
            tick();
            n++;
        end
        check("t4_ret_pop_seen", 32'(stack_pop), 32'h1);
        tick(); tick();
        check("t4_fetch_after_ret", 32'(rom_addr), 32'h06);
        wait_halt("t4_halt");
        check("t4_pc_at_halt", 32'(rom_addr), 32'h07);
        end_program("t4_sb_drained");

        // PUSH/POP round trip through the stack
        clear_rom();
        rom[0] = ins(5'h01, 8'h55);
        rom[1] = ins(5'h0A, 8'h00);
        rom[2] = ins(5'h01, 8'h00);
        rom[3] = ins(5'h0B, 8'h00);
        exp_q.push_back(ev(4'd1, 4'd1, 4'd0, 8'h00, 8'h55));
        exp_q.push_back(ev(4'd3, 4'd0, 4'd0, 8'h00, 8'h55));
        exp_q.push_back(ev(4'd1, 4'd1, 4'd0, 8'h00, 8'h00));
        exp_q.push_back(ev(4'd4, 4'd0, 4'd0, 8'h00, 8'h00));
        exp_q.push_back(ev(4'd1, 4'd3, 4'd0, 8'h00, 8'h55));
        reset_dut();
        wait_halt("t5_halt");
        check("t5_acc", 32'(acc), 32'h55);
        end_program("t5_sb_drained");

        // Jump to 0xFF: PC wraps to 0x00 after DECODE
        clear_rom();
        rom[0] = ins(5'h08, 8'hFF);
        rom[8'hFF] = ins(5'h00, 8'h00);
        reset_dut();
        tick(); tick(); tick();
        check("t6_pc_after_jmp", 32'(rom_addr), 32'hFF);
        tick(); tick();
        check("t6_pc_wrap", 32'(rom_addr), 32'h00);
        tick();
        check("t6_refetch_0", {24'h0, rom_addr}, {31'h0, halted});
        end_program("t6_sb_drained");

        // POP on an empty stack
        clear_rom();
        rom[0] = ins(5'h0B, 8'h00);
`ifndef STACK_GUARD_EN
        exp_q.push_back(ev(4'd4, 4'd0, 4'd0, 8'h00, 8'h00));
        exp_q.push_back(ev(4'd1, 4'd3, 4'd0, 8'h00, 8'h00));
`endif
        reset_dut();
        wait_halt("t7_halt");
`ifdef STACK_GUARD_EN
        check("t7_fault", 32'(fault), 32'h1);
        check("t7_pc_frozen", 32'(rom_addr), 32'h01);
`else
        check("t7_fault", 32'(fault), 32'h0);
        check("t7_pc_at_halt", 32'(rom_addr), 32'h02);
`endif
        end_program("t7_sb_drained");

        // Reset asserted during MEM of LD aborts the load
        clear_rom();
        rom[0] = ins(5'h02, 8'h10);
        reset_dut();
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        check("t8_acc_we_dropped", {31'h0, acc_we}, 32'h0);
        check("t8_pc_cleared", {24'h0, rom_addr}, 32'h0);
        check("t8_idle_ctrl", {28'h0, ram_we, stack_push, stack_pop, halted}, 32'h0);
        tick(); tick();
        check("t8_acc_unloaded", 32'(acc), 32'h00);
        end_program("t8_sb_drained");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
